// File: rtl/ram_be_pipe.sv
// ram_be_pipe: single-port byte-enable RAM slave with req/gnt and rvalid/rready handshake.
// Reads are registered with 1- or 2-cycle latency; misaligned or out-of-range accesses return err_o.
module ram_be_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4096,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  input  logic                rready_i
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int MEM_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [MEM_W-1:0]  midx;
  logic              bad, stall, acc;
  logic              s0_valid, s0_err;
  logic [DATA_W-1:0] s0_data;
  assign idx   = addr_i[ADDR_W-1:OFF_W];
  assign midx  = idx[MEM_W-1:0];
  assign bad   = (|addr_i[OFF_W-1:0]) || ({1'b0, idx} >= (IDX_W+1)'(DEPTH));
  assign stall = rvalid_o && !rready_i;
  assign gnt_o = !stall;
  assign acc   = req_i && gnt_o;
  // array is never reset; a write presented while rst is high is dropped
  always_ff @(posedge clk)
    if (acc && we_i && !bad && !rst)
      for (int k = 0; k < BE_W; k++)
        if (be_i[k]) mem[midx][8*k +: 8] <= data_i[8*k +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0_valid <= 1'b0;
      s0_err   <= 1'b0;
      s0_data  <= '0;
    end else if (!stall) begin
      s0_valid <= acc;
      s0_err   <= acc && bad;
      s0_data  <= (acc && !we_i && !bad) ? mem[midx] : '0;
    end
  if (READ_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rvalid_o <= 1'b0;
        err_o    <= 1'b0;
        rdata_o  <= '0;
      end else if (!stall) begin
        rvalid_o <= s0_valid;
        err_o    <= s0_err;
        rdata_o  <= s0_data;
      end
  end else begin : g_lat1
    assign rvalid_o = s0_valid;
    assign err_o    = s0_err;
    assign rdata_o  = s0_data;
  end
endmodule
